// File: rtl/pipeline_core_param.sv
// Parametrised 5-stage (IF/ID/EX/MEM/WB) in-order integer pipeline with
// EX-operand forwarding, load-use stall, branch/jump flush and external memories.
module pipeline_core_param #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned PC_W     = 12,
   parameter int unsigned RA_W     = 4,
   parameter int unsigned DADDR_W  = 8,
   parameter int unsigned RESET_PC = 0,
   localparam int unsigned INST_W  = 4 + 3 * RA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INST_W-1:0]  imem_data,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   output logic               dmem_we,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic [DATA_W-1:0]  result_w,
   output logic               retire_valid,
   output logic [RA_W-1:0]    retire_rd,
   output logic               stall_o,
   output logic               flush_o
);

   localparam int unsigned NUM_REGS = 1 << RA_W;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LD   = 4'd6;
   localparam logic [3:0] OP_ST   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;

   logic [PC_W-1:0]   pc_q, pc_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
   logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;

   logic              idex_valid_q, idex_valid_d;
   logic [3:0]        idex_op_q, idex_op_d;
   logic [RA_W-1:0]   idex_rd_q, idex_rd_d, idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d;
   logic [DATA_W-1:0] idex_dv_q, idex_dv_d, idex_av_q, idex_av_d, idex_bv_q, idex_bv_d;
   logic [PC_W-1:0]   idex_pc_q, idex_pc_d;

   logic              exmem_wr_q, exmem_wr_d, exmem_ld_q, exmem_ld_d, exmem_st_q, exmem_st_d;
   logic [RA_W-1:0]   exmem_rd_q, exmem_rd_d;
   logic [DATA_W-1:0] exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d;

   logic              memwb_wr_q, memwb_wr_d;
   logic [RA_W-1:0]   memwb_rd_q, memwb_rd_d;
   logic [DATA_W-1:0] memwb_res_q, memwb_res_d;

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic [3:0]        id_op;
   logic [RA_W-1:0]   id_rd, id_rs, id_rt;
   logic [DATA_W-1:0] id_dv, id_av, id_bv;
   logic              id_uses_rd, id_uses_rs, id_uses_rt;
   logic              wb_we, load_use;

   logic [DATA_W-1:0] ex_a, ex_b, ex_d, ex_imm, ex_res;
   logic              ex_taken;
   logic [PC_W-1:0]   ex_target;

   assign id_op = ifid_inst_q[INST_W-1 -: 4];
   assign id_rd = ifid_inst_q[3*RA_W-1 -: RA_W];
   assign id_rs = ifid_inst_q[2*RA_W-1 -: RA_W];
   assign id_rt = ifid_inst_q[RA_W-1:0];

   assign wb_we = enable && memwb_wr_q && (memwb_rd_q != '0);

   // Register read with write-first bypass from the retiring WB value
   always_comb begin
      id_dv = (id_rd == '0) ? '0 : (wb_we && memwb_rd_q == id_rd) ? memwb_res_q : regs_q[id_rd];
      id_av = (id_rs == '0) ? '0 : (wb_we && memwb_rd_q == id_rs) ? memwb_res_q : regs_q[id_rs];
      id_bv = (id_rt == '0) ? '0 : (wb_we && memwb_rd_q == id_rt) ? memwb_res_q : regs_q[id_rt];
   end

   always_comb begin
      id_uses_rs = (id_op >= OP_ADD) && (id_op <= OP_BEQ);
      id_uses_rt = (id_op >= OP_ADD) && (id_op <= OP_OR);
      id_uses_rd = (id_op == OP_ST) || (id_op == OP_BEQ);
      load_use   = ifid_valid_q && idex_valid_q && (idex_op_q == OP_LD) && (idex_rd_q != '0) &&
                   ((id_uses_rs && id_rs == idex_rd_q) ||
                    (id_uses_rt && id_rt == idex_rd_q) ||
                    (id_uses_rd && id_rd == idex_rd_q));
   end

   // A load still in MEM has no data yet, so only non-load EX/MEM writers forward
   function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] a,
                                              input logic [DATA_W-1:0] cap);
      if (a != '0 && exmem_wr_q && !exmem_ld_q && exmem_rd_q == a) return exmem_res_q;
      else if (a != '0 && memwb_wr_q && memwb_rd_q == a) return memwb_res_q;
      else return cap;
   endfunction

   always_comb begin
      ex_a   = fwd(idex_rs_q, idex_av_q);
      ex_b   = fwd(idex_rt_q, idex_bv_q);
      ex_d   = fwd(idex_rd_q, idex_dv_q);
      ex_imm = DATA_W'(idex_rt_q);
      case (idex_op_q)
         OP_ADD:                ex_res = ex_a + ex_b;
         OP_SUB:                ex_res = ex_a - ex_b;
         OP_AND:                ex_res = ex_a & ex_b;
         OP_OR:                 ex_res = ex_a | ex_b;
         OP_ADDI, OP_LD, OP_ST: ex_res = ex_a + ex_imm;
         default:               ex_res = '0;
      endcase
      ex_taken  = idex_valid_q && (((idex_op_q == OP_BEQ) && (ex_d == ex_a)) || (idex_op_q == OP_JMP));
      ex_target = (idex_op_q == OP_JMP) ? PC_W'({idex_rd_q, idex_rs_q, idex_rt_q})
                                        : idex_pc_q + PC_W'(1) + PC_W'($signed(idex_rt_q));
   end

   always_comb begin
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pc_d    = ifid_pc_q;
      idex_valid_d = idex_valid_q;
      idex_op_d    = idex_op_q;
      idex_rd_d    = idex_rd_q;
      idex_rs_d    = idex_rs_q;
      idex_rt_d    = idex_rt_q;
      idex_dv_d    = idex_dv_q;
      idex_av_d    = idex_av_q;
      idex_bv_d    = idex_bv_q;
      idex_pc_d    = idex_pc_q;
      // Redirect beats a stall: both younger stages become bubbles
      if (ex_taken) begin
         pc_d         = ex_target;
         ifid_valid_d = 1'b0;
         idex_valid_d = 1'b0;
         idex_op_d    = OP_NOP;
      end else if (load_use) begin
         idex_valid_d = 1'b0;
         idex_op_d    = OP_NOP;
      end else begin
         pc_d         = pc_q + PC_W'(1);
         ifid_valid_d = 1'b1;
         ifid_inst_d  = imem_data;
         ifid_pc_d    = pc_q;
         idex_valid_d = ifid_valid_q;
         idex_op_d    = ifid_valid_q ? id_op : OP_NOP;
         idex_rd_d    = id_rd;
         idex_rs_d    = id_rs;
         idex_rt_d    = id_rt;
         idex_dv_d    = id_dv;
         idex_av_d    = id_av;
         idex_bv_d    = id_bv;
         idex_pc_d    = ifid_pc_q;
      end
      exmem_wr_d  = idex_valid_q && (idex_op_q >= OP_ADD) && (idex_op_q <= OP_LD);
      exmem_ld_d  = idex_valid_q && (idex_op_q == OP_LD);
      exmem_st_d  = idex_valid_q && (idex_op_q == OP_ST);
      exmem_rd_d  = idex_rd_q;
      exmem_res_d = ex_res;
      exmem_sd_d  = ex_d;
      memwb_wr_d  = exmem_wr_q;
      memwb_rd_d  = exmem_rd_q;
      memwb_res_d = exmem_ld_q ? dmem_rdata : exmem_res_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= PC_W'(RESET_PC);
         ifid_valid_q <= 1'b0;
         ifid_inst_q  <= '0;
         ifid_pc_q    <= '0;
         idex_valid_q <= 1'b0;
         idex_op_q    <= OP_NOP;
         idex_rd_q    <= '0;
         idex_rs_q    <= '0;
         idex_rt_q    <= '0;
         idex_dv_q    <= '0;
         idex_av_q    <= '0;
         idex_bv_q    <= '0;
         idex_pc_q    <= '0;
         exmem_wr_q   <= 1'b0;
         exmem_ld_q   <= 1'b0;
         exmem_st_q   <= 1'b0;
         exmem_rd_q   <= '0;
         exmem_res_q  <= '0;
         exmem_sd_q   <= '0;
         memwb_wr_q   <= 1'b0;
         memwb_rd_q   <= '0;
         memwb_res_q  <= '0;
      end else if (enable) begin
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_pc_q    <= ifid_pc_d;
         idex_valid_q <= idex_valid_d;
         idex_op_q    <= idex_op_d;
         idex_rd_q    <= idex_rd_d;
         idex_rs_q    <= idex_rs_d;
         idex_rt_q    <= idex_rt_d;
         idex_dv_q    <= idex_dv_d;
         idex_av_q    <= idex_av_d;
         idex_bv_q    <= idex_bv_d;
         idex_pc_q    <= idex_pc_d;
         exmem_wr_q   <= exmem_wr_d;
         exmem_ld_q   <= exmem_ld_d;
         exmem_st_q   <= exmem_st_d;
         exmem_rd_q   <= exmem_rd_d;
         exmem_res_q  <= exmem_res_d;
         exmem_sd_q   <= exmem_sd_d;
         memwb_wr_q   <= memwb_wr_d;
         memwb_rd_q   <= memwb_rd_d;
         memwb_res_q  <= memwb_res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wb_we) begin
         regs_q[memwb_rd_q] <= memwb_res_q;
      end
   end

   assign imem_addr    = pc_q;
   assign dmem_addr    = DADDR_W'(exmem_res_q);
   assign dmem_wdata   = exmem_sd_q;
   assign dmem_we      = enable && exmem_st_q;
   assign result_w     = memwb_res_q;
   assign retire_valid = enable && memwb_wr_q;
   assign retire_rd    = memwb_rd_q;
   assign stall_o      = enable && load_use && !ex_taken;
   assign flush_o      = enable && ex_taken;

endmodule
